mem_result_streamer: RTL and testbench
======================================

# mem_result_streamer

Parametrised per-read SMEM result store and cache-line streamer for the SMEM pipeline back end. It collects compressed mem entries, per-read mem sizes and ret values for a batch of reads. Once every read in the batch has reported its size, it streams one header line plus packed entry lines per read on a 512-bit valid/ready output. It adds four things: configurable depth and read count, true backpressure, gap-free group streaming, and overflow detection.

## Interface
Parameters:
- NUM_READS, 256, max reads per batch
- READ_NUM_W, 8, read-number width, equal to clog2(NUM_READS)
- MAX_MEM, 40, max mem entries per read
- IDX_W, 7, entry index / size width
- ENTRY_W, 113, compressed entry width (33+33+33+7+7)

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- stall  in  1  pipeline stall; while high, all collection-side inputs are ignored
- batch_size  in  READ_NUM_W+1  reads in the batch; sampled continuously and must be held stable per batch
- wr_valid  in  1  mem entry write
- wr_read_num  in  READ_NUM_W  read owning the entry
- wr_idx  in  IDX_W  entry slot within the read
- wr_data  in  256  entry record {info[230:224], info[198:192], x2[160:128], x1[96:64], x0[32:0]}; all other bits are don't-care
- size_valid  in  1  a read's mem count is final
- size_read_num  in  READ_NUM_W  read number for size_valid
- size  in  IDX_W  mem count for that read
- ret_valid  in  1  ret value write
- ret_read_num  in  READ_NUM_W  read number for ret_valid
- ret  in  7  ret value
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer accepts the beat
- out_data  out  512  output line
- out_last  out  1  marks the final beat of the batch
- overflow_err  out  1  sticky error flag

## Operation
- Collection (state COLLECT), each cycle with !stall:
  - wr_valid: compress wr_data into ENTRY_W bits and write it at address wr_read_num*MAX_MEM+wr_idx.
  - size_valid: store size in size_tab[size_read_num] and increment done_cnt (READ_NUM_W+1 bits).
  - ret_valid: store ret in ret_tab[ret_read_num].
- Errors and clamping:
  - wr_idx >= MAX_MEM: the write is dropped and overflow_err is set.
  - size > MAX_MEM: MAX_MEM is stored and overflow_err is set.
- Simultaneous size_valid and ret_valid for the same read are both accepted.
- Any wr_valid, size_valid or ret_valid outside COLLECT is ignored and sets overflow_err.
- COLLECT moves to HDR when done_cnt == batch_size and batch_size != 0. batch_size == 0 keeps the block in COLLECT.
- FSM states: COLLECT, HDR, BODY, DONE. Read pointer rp starts at 0 and entry pointer ep at 0.
- HDR beat:
  - out_data[9:0] = rp (zero-extended)
  - out_data[70:64] = size_tab[rp]
  - out_data[134:128] = ret_tab[rp]
  - all other bits 0
- Leaving HDR on handshake:
  - size_tab[rp] == 0 → next read's HDR; if rp was the last read (rp == batch_size-1), → DONE.
  - otherwise → BODY.
- BODY beat:
  - Lane 0 (bits 255:0) is entry ep, expanded to the wr_data layout with unused bits 0.
  - Lane 1 (bits 511:256) is entry ep+1 with the same layout, or all-zero when ep+1 == size.
  - On handshake, ep advances by 2.
  - When ep+2 >= size: ep resets to 0 and rp increments → next read's HDR, or DONE after the last read.
- out_last is asserted with the last beat of the batch, whether that beat is a header or a body line.
- DONE: out_valid=0. The block stays in DONE until reset; the table contents are retained.
- Reset-to-reset handling of a new batch is the owner's responsibility.

## Timing
- Reset values: out_valid=0, out_last=0, out_data=0, overflow_err=0, state=COLLECT, done_cnt=0. The tables are not reset.
- Write path: one pipeline register stage from input to RAM write. A write is visible to reads 2 cycles after it is presented.
- COLLECT→HDR is decided 1 cycle after the last size_valid. The first out_valid follows at most 3 cycles later.
- Throughput: while out_ready is held high, one beat per cycle with no gap between groups. This uses a 2-deep prefetch/skid buffer ahead of the 1-cycle-latency RAM.
- Handshake rules:
  - out_data and out_last are held stable while out_valid && !out_ready.
  - out_valid never deasserts without a handshake.
- The output side does not observe stall.
- Reset mid-stream: the next cycle gives out_valid=0 and state=COLLECT.

## Structure
- Package smem_pkg holds:
  - CL=512
  - ENTRY_W
  - the field bit positions of the 256-bit record
  - pack_entry() (256→113) and unpack_entry() (113→256, zero-fill) functions
  - the FSM state enum
- Sub-module mem_entry_ram:
  - 1 write port and 2 read ports
  - NUM_READS*MAX_MEM deep, ENTRY_W wide
  - registered reads with read enable
- size_tab and ret_tab are small register arrays kept in the top level.

## Test plan
- batch_size=2:
  - stimulus: read0 size=3 with entries A,B,C and ret=5; read1 size=0 with ret=1; out_ready=1
  - response: 4 beats — HDR(0,3,5), {A,B}, {C,0}, HDR(1,0,1) with out_last=1
- Backpressure: same batch with out_ready toggled randomly → identical beat sequence, and out_data is stable during every stall.
- stall held high while wr_valid/size_valid are pulsed → nothing stored; done_cnt does not advance and no output appears.
- wr_idx=40 with MAX_MEM=40 → write dropped, overflow_err=1. size=50 → header shows size 40.
- size_valid arriving in COLLECT in the same cycle as another read's final size_valid → both counted, and HDR starts exactly once.
- Reset asserted during BODY → out_valid=0 the next cycle. A fresh batch then streams correctly.

Source files
------------

// File: rtl/smem_pkg.sv
// Shared widths, record field map, entry packing and FSM states
// for the SMEM result streamer.
package smem_pkg;

    localparam int CL      = 512;
    localparam int REC_W   = 256;
    localparam int ENTRY_W = 113;
    localparam int X_W     = 33;
    localparam int INFO_W  = 7;

    localparam int X0_LO    = 0;
    localparam int X1_LO    = 64;
    localparam int X2_LO    = 128;
    localparam int INFO0_LO = 192;
    localparam int INFO1_LO = 224;

    typedef enum logic [1:0] {
        COLLECT,
        HDR,
        BODY,
        DONE
    } state_e;

    function automatic logic [ENTRY_W-1:0] pack_entry(
        input logic [REC_W-1:0] rec
    );
        return {rec[INFO1_LO +: INFO_W],
                rec[INFO0_LO +: INFO_W],
                rec[X2_LO +: X_W],
                rec[X1_LO +: X_W],
                rec[X0_LO +: X_W]};
    endfunction

    function automatic logic [REC_W-1:0] unpack_entry(
        input logic [ENTRY_W-1:0] e
    );
        logic [REC_W-1:0] rec;
        rec = '0;
        rec[X0_LO +: X_W]       = e[0 +: X_W];
        rec[X1_LO +: X_W]       = e[X_W +: X_W];
        rec[X2_LO +: X_W]       = e[2*X_W +: X_W];
        rec[INFO0_LO +: INFO_W] = e[3*X_W +: INFO_W];
        rec[INFO1_LO +: INFO_W] = e[3*X_W+INFO_W +: INFO_W];
        return rec;
    endfunction

endpackage

// File: rtl/mem_entry_ram.sv
// Compressed mem-entry store: one write port, two registered
// read ports with read enables.
module mem_entry_ram
    import smem_pkg::*;
#(
    parameter int DEPTH = 10240,
    parameter int AW    = 14,
    parameter int W     = ENTRY_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re0,
    input  logic [AW-1:0] raddr0,
    output logic [W-1:0]  rdata0,
    input  logic          re1,
    input  logic [AW-1:0] raddr1,
    output logic [W-1:0]  rdata1
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re0) begin
            rdata0 <= mem[raddr0];
        end
        if (re1) begin
            rdata1 <= mem[raddr1];
        end
    end

endmodule

// File: rtl/mem_result_streamer.sv
// Per-read SMEM result store; streams a header line plus packed
// entry lines per read once the whole batch has reported sizes.
module mem_result_streamer
    import smem_pkg::*;
#(
    parameter int NUM_READS  = 256,
    parameter int READ_NUM_W = 8,
    parameter int MAX_MEM    = 40,
    parameter int IDX_W      = 7,
    parameter int ENTRY_W    = 113
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  stall,
    input  logic [READ_NUM_W:0]   batch_size,
    input  logic                  wr_valid,
    input  logic [READ_NUM_W-1:0] wr_read_num,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [255:0]          wr_data,
    input  logic                  size_valid,
    input  logic [READ_NUM_W-1:0] size_read_num,
    input  logic [IDX_W-1:0]      size,
    input  logic                  ret_valid,
    input  logic [READ_NUM_W-1:0] ret_read_num,
    input  logic [6:0]            ret,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CL-1:0]         out_data,
    output logic                  out_last,
    output logic                  overflow_err
);

    localparam int DEPTH = NUM_READS * MAX_MEM;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = READ_NUM_W + 1;
    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(MAX_MEM);

    state_e                state_q, state_d;
    logic [READ_NUM_W-1:0] rp_q, rp_d;
    logic [IDX_W-1:0]      ep_q, ep_d;
    logic [CW-1:0]         done_cnt;

    logic [IDX_W-1:0] size_tab [NUM_READS];
    logic [6:0]       ret_tab  [NUM_READS];

    logic collect;
    logic wr_acc, size_acc, ret_acc, err_hit;

    assign collect  = state_q == COLLECT;
    assign wr_acc   = !stall && wr_valid && collect
                    && (wr_idx < MAX_IDX);
    assign size_acc = !stall && size_valid && collect;
    assign ret_acc  = !stall && ret_valid && collect;
    assign err_hit  = !stall && (
          (wr_valid && (!collect || wr_idx >= MAX_IDX))
       || (size_valid && (!collect || size > MAX_IDX))
       || (ret_valid && !collect));

    // Write path: one register stage in front of the RAM port.
    logic               wq_valid;
    logic [AW-1:0]      wq_addr;
    logic [ENTRY_W-1:0] wq_data;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wq_valid <= 1'b0;
        end else begin
            wq_valid <= wr_acc;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            wq_addr <= AW'(wr_read_num) * AW'(MAX_MEM)
                     + AW'(wr_idx);
            wq_data <= pack_entry(wr_data);
        end
    end

    always_ff @(posedge clk) begin
        if (size_acc) begin
            size_tab[size_read_num] <=
                (size > MAX_IDX) ? MAX_IDX : size;
        end
        if (ret_acc) begin
            ret_tab[ret_read_num] <= ret;
        end
    end

    // Beat generator: walks the output sequence and issues reads.
    logic [IDX_W-1:0]  cur_size;
    logic [IDX_W:0]    ep_plus2;
    logic              last_read, start, body_end, zero1;
    logic              credit;
    logic              issue, iss_hdr, iss_last, iss_zero1;
    logic              re0, re1;
    logic [AW-1:0]     raddr0, raddr1;

    assign cur_size  = size_tab[rp_q];
    assign last_read = {1'b0, rp_q} == batch_size - CW'(1);
    assign start     = collect && (done_cnt == batch_size)
                     && (batch_size != '0);
    assign ep_plus2  = {1'b0, ep_q} + (IDX_W+1)'(2);
    assign body_end  = ep_plus2 >= {1'b0, cur_size};
    assign zero1     = (ep_q + IDX_W'(1)) == cur_size;
    assign raddr0    = AW'(rp_q) * AW'(MAX_MEM) + AW'(ep_q);
    assign raddr1    = raddr0 + AW'(1);

    always_comb begin
        state_d   = state_q;
        rp_d      = rp_q;
        ep_d      = ep_q;
        issue     = 1'b0;
        iss_hdr   = 1'b0;
        iss_last  = 1'b0;
        iss_zero1 = 1'b0;
        re0       = 1'b0;
        re1       = 1'b0;
        unique case (state_q)
            COLLECT: begin
                if (start) begin
                    state_d = HDR;
                end
            end
            HDR: begin
                if (credit) begin
                    issue   = 1'b1;
                    iss_hdr = 1'b1;
                    if (cur_size != '0) begin
                        state_d = BODY;
                    end else if (last_read) begin
                        iss_last = 1'b1;
                        state_d  = DONE;
                    end else begin
                        rp_d = rp_q + 1'b1;
                    end
                end
            end
            BODY: begin
                if (credit) begin
                    issue     = 1'b1;
                    re0       = 1'b1;
                    re1       = !zero1;
                    iss_zero1 = zero1;
                    if (!body_end) begin
                        ep_d = ep_q + IDX_W'(2);
                    end else begin
                        ep_d = '0;
                        if (last_read) begin
                            iss_last = 1'b1;
                            state_d  = DONE;
                        end else begin
                            rp_d    = rp_q + 1'b1;
                            state_d = HDR;
                        end
                    end
                end
            end
            DONE: begin
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= COLLECT;
            rp_q         <= '0;
            ep_q         <= '0;
            done_cnt     <= '0;
            overflow_err <= 1'b0;
        end else begin
            state_q <= state_d;
            rp_q    <= rp_d;
            ep_q    <= ep_d;
            if (size_acc) begin
                done_cnt <= done_cnt + CW'(1);
            end
            if (err_hit) begin
                overflow_err <= 1'b1;
            end
        end
    end

    logic [ENTRY_W-1:0] rd0, rd1;

    mem_entry_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (ENTRY_W)
    ) u_ram (
        .clk    (clk),
        .we     (wq_valid),
        .waddr  (wq_addr),
        .wdata  (wq_data),
        .re0    (re0),
        .raddr0 (raddr0),
        .rdata0 (rd0),
        .re1    (re1),
        .raddr1 (raddr1),
        .rdata1 (rd1)
    );

    // Landing stage: metadata travels alongside the RAM read.
    logic                  l_valid, l_hdr, l_last, l_zero1;
    logic [READ_NUM_W-1:0] l_rp;
    logic [IDX_W-1:0]      l_size;
    logic [6:0]            l_ret;
    logic [CL-1:0]         beat;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            l_valid <= 1'b0;
        end else begin
            l_valid <= issue;
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            l_hdr   <= iss_hdr;
            l_last  <= iss_last;
            l_zero1 <= iss_zero1;
            l_rp    <= rp_q;
            l_size  <= cur_size;
            l_ret   <= ret_tab[rp_q];
        end
    end

    always_comb begin
        beat = '0;
        if (l_hdr) begin
            beat[9:0]           = 10'(l_rp);
            beat[64 +: IDX_W]   = l_size;
            beat[134:128]       = l_ret;
        end else begin
            beat[255:0] = unpack_entry(rd0);
            if (!l_zero1) begin
                beat[511:256] = unpack_entry(rd1);
            end
        end
    end

    // Two-entry skid buffer; credit keeps room for the beat in flight.
    logic [CL-1:0] fifo_data [2];
    logic [1:0]    fifo_last;
    logic          wr_ptr, rd_ptr;
    logic [1:0]    occ;
    logic          push, pop;
    logic [2:0]    fill;

    assign push   = l_valid;
    assign pop    = out_valid && out_ready;
    assign fill   = 3'(occ) + 3'(l_valid) - 3'(pop);
    assign credit = fill < 3'd2;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            occ          <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            fifo_last    <= '0;
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= beat;
                fifo_last[wr_ptr] <= l_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

    assign out_valid = occ != 2'd0;
    assign out_data  = fifo_data[rd_ptr];
    assign out_last  = fifo_last[rd_ptr] & out_valid;

endmodule

// File: tb/tb_mem_result_streamer.sv
// Randomised bench for mem_result_streamer against a beat-list model.
module tb_mem_result_streamer;

    localparam int NR  = 256;
    localparam int RNW = 8;
    localparam int MM  = 40;
    localparam int IW  = 7;
    localparam int MR  = 8;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           stall;
    logic [RNW:0]   batch_size;
    logic           wr_valid;
    logic [RNW-1:0] wr_read_num;
    logic [IW-1:0]  wr_idx;
    logic [255:0]   wr_data;
    logic           size_valid;
    logic [RNW-1:0] size_read_num;
    logic [IW-1:0]  size;
    logic           ret_valid;
    logic [RNW-1:0] ret_read_num;
    logic [6:0]     ret;
    logic           out_valid;
    logic           out_ready;
    logic [511:0]   out_data;
    logic           out_last;
    logic           overflow_err;

    always #5 clk = ~clk;

    mem_result_streamer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .stall         (stall),
        .batch_size    (batch_size),
        .wr_valid      (wr_valid),
        .wr_read_num   (wr_read_num),
        .wr_idx        (wr_idx),
        .wr_data       (wr_data),
        .size_valid    (size_valid),
        .size_read_num (size_read_num),
        .size          (size),
        .ret_valid     (ret_valid),
        .ret_read_num  (ret_read_num),
        .ret           (ret),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_last      (out_last),
        .overflow_err  (overflow_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [511:0] got,
                         input logic [511:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: requested sizes, rets and expanded entries.
    logic [255:0] m_ent [MR][MM];
    int           m_req [MR];
    int           m_ret [MR];
    logic [511:0] expq [$];
    logic         lastq [$];
    logic [255:0] fmask;

    function automatic logic [255:0] field_mask();
        logic [255:0] m;
        for (int b = 0; b < 256; b++)
            m[b] = (b <= 32) || (b >= 64 && b <= 96)
                || (b >= 128 && b <= 160) || (b >= 192 && b <= 198)
                || (b >= 224 && b <= 230);
        return m;
    endfunction

    function automatic logic [255:0] rand256();
        return {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int clampsz(input int s);
        return (s > MM) ? MM : s;
    endfunction

    task automatic idle_inputs();
        stall = 0; wr_valid = 0; size_valid = 0; ret_valid = 0;
        wr_read_num = 0; wr_idx = 0; wr_data = '0;
        size_read_num = 0; size = 0; ret_read_num = 0; ret = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 0; out_ready = 0; batch_size = '0;
        repeat (2) @(negedge clk);
        reset_n = 1;
    endtask

    task automatic drive_wr(input int r, input int i,
                            input logic [255:0] d);
        wr_valid = 1; wr_read_num = RNW'(r);
        wr_idx = IW'(i); wr_data = d;
        @(negedge clk);
        wr_valid = 0;
    endtask

    task automatic junk_stall(input int nreads);
        stall = 1;
        wr_valid = 1; wr_read_num = RNW'($urandom_range(nreads - 1));
        wr_idx = IW'($urandom_range(MM - 1)); wr_data = rand256();
        size_valid = 1; size_read_num = 0; size = 0;
        ret_valid = 1; ret_read_num = 0; ret = 7'($urandom);
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic write_entries(input int nreads);
        for (int r = 0; r < nreads; r++)
            for (int i = 0; i < clampsz(m_req[r]); i++) begin
                logic [255:0] d;
                d = rand256();
                m_ent[r][i] = d & fmask;
                drive_wr(r, i, d);
                if ($urandom_range(3) == 0) junk_stall(nreads);
            end
    endtask

    task automatic send_sizes(input int nreads);
        for (int r = 0; r < nreads; r++) begin
            size_valid = 1; size_read_num = RNW'(r);
            size = IW'(m_req[r]);
            ret_valid = 1; ret_read_num = RNW'(r);
            ret = 7'(m_ret[r]);
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic collect(input int nreads);
        batch_size = (RNW+1)'(nreads);
        write_entries(nreads);
        send_sizes(nreads);
    endtask

    task automatic build_exp(input int nreads);
        expq.delete(); lastq.delete();
        for (int r = 0; r < nreads; r++) begin
            int sz;
            logic [511:0] b;
            sz = clampsz(m_req[r]);
            b = '0;
            b[9:0] = 10'(r);
            b[70:64] = 7'(sz);
            b[134:128] = 7'(m_ret[r]);
            expq.push_back(b);
            lastq.push_back(r == nreads - 1 && sz == 0);
            for (int e = 0; e < sz; e += 2) begin
                b = '0;
                b[255:0] = m_ent[r][e];
                if (e + 1 < sz) b[511:256] = m_ent[r][e + 1];
                expq.push_back(b);
                lastq.push_back(r == nreads - 1 && e + 2 >= sz);
            end
        end
    endtask

    task automatic run_stream(input int pct, input int max_wait);
        int budget, wait_n, gaps;
        bit seen, held;
        logic [511:0] hold_d;
        logic hold_l;
        budget = 5000; wait_n = 0; gaps = 0;
        seen = 0; held = 0; hold_d = '0; hold_l = 0;
        while (expq.size() > 0 && budget > 0) begin
            out_ready = ($urandom_range(99) < pct);
            if (out_valid) begin
                if (!seen) begin
                    seen = 1;
                    if (max_wait >= 0)
                        check("first_valid_latency",
                              512'(wait_n <= max_wait), 512'(1));
                end
                if (held) begin
                    check("hold_data", out_data, hold_d);
                    check("hold_last", 512'(out_last), 512'(hold_l));
                end
                if (out_ready) begin
                    check("beat_data", out_data, expq.pop_front());
                    check("beat_last", 512'(out_last),
                          512'(lastq.pop_front()));
                    held = 0;
                end else begin
                    held = 1; hold_d = out_data; hold_l = out_last;
                end
            end else begin
                if (held) check("valid_held", 512'(out_valid), 512'(1));
                if (!seen) wait_n++;
                else gaps++;
                held = 0;
            end
            @(negedge clk);
            budget--;
        end
        check("beats_left", 512'(expq.size()), 512'(0));
        if (pct == 100) check("gap_free", 512'(gaps), 512'(0));
        out_ready = 1;
        for (int k = 0; k < 4; k++) begin
            check("no_extra_beat", 512'(out_valid), 512'(0));
            @(negedge clk);
        end
    endtask

    initial begin
        int nreads;
        bit got;
        logic [255:0] a;
        fmask = field_mask();
        do_reset();
        check("rst_out_valid", 512'(out_valid), 512'(0));
        check("rst_out_last", 512'(out_last), 512'(0));
        check("rst_out_data", out_data, '0);
        check("rst_overflow", 512'(overflow_err), 512'(0));

        // directed two-read batch
        m_req[0] = 3; m_ret[0] = 5; m_req[1] = 0; m_ret[1] = 1;
        collect(2);
        build_exp(2);
        check("dir_beat_count", 512'(expq.size()), 512'(4));
        run_stream(100, 4);
        check("ovf_before_late", 512'(overflow_err), 512'(0));
        drive_wr(0, 0, rand256());
        @(negedge clk);
        check("ovf_late_write", 512'(overflow_err), 512'(1));

        // same batch under random backpressure
        do_reset();
        collect(2);
        build_exp(2);
        run_stream(45, 4);

        // stall masks collection
        do_reset();
        batch_size = 1;
        a = rand256();
        m_ent[0][0] = a & fmask;
        drive_wr(0, 0, a);
        stall = 1;
        wr_valid = 1; wr_read_num = 0; wr_idx = 0; wr_data = ~a;
        size_valid = 1; size_read_num = 0; size = 1;
        ret_valid = 1; ret_read_num = 0; ret = 7'd9;
        repeat (3) @(negedge clk);
        idle_inputs();
        got = 0;
        for (int k = 0; k < 10; k++) begin
            if (out_valid) got = 1;
            @(negedge clk);
        end
        check("stall_no_output", 512'(got), 512'(0));
        check("stall_no_ovf", 512'(overflow_err), 512'(0));
        m_req[0] = 1; m_ret[0] = 3;
        send_sizes(1);
        build_exp(1);
        run_stream(100, 4);

        // index overflow and size clamping
        do_reset();
        batch_size = 2;
        m_req[0] = 50; m_ret[0] = 7; m_req[1] = 1; m_ret[1] = 2;
        a = rand256();
        m_ent[1][0] = a & fmask;
        drive_wr(1, 0, a);
        for (int i = 0; i < MM; i++) begin
            a = rand256();
            m_ent[0][i] = a & fmask;
            drive_wr(0, i, a);
        end
        @(negedge clk);
        check("ovf_clear", 512'(overflow_err), 512'(0));
        drive_wr(0, MM, rand256());
        @(negedge clk);
        check("ovf_idx", 512'(overflow_err), 512'(1));
        send_sizes(2);
        build_exp(2);
        run_stream(70, 4);

        // randomised batches, back-to-back sizes
        for (int it = 0; it < 4; it++) begin
            do_reset();
            nreads = $urandom_range(1, 6);
            for (int r = 0; r < nreads; r++) begin
                m_req[r] = ($urandom_range(7) == 0) ? $urandom_range(MM, 45)
                                                   : $urandom_range(0, MM);
                m_ret[r] = $urandom_range(127);
            end
            collect(nreads);
            build_exp(nreads);
            run_stream((it == 0) ? 100 : $urandom_range(30, 90), 4);
        end

        // reset during body, then a fresh batch
        do_reset();
        m_req[0] = 30; m_ret[0] = 4;
        collect(1);
        out_ready = 1;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            if (out_valid) got = 1;
            else @(negedge clk);
        end
        check("body_reached", 512'(got), 512'(1));
        repeat (3) @(negedge clk);
        check("mid_body_valid", 512'(out_valid), 512'(1));
        reset_n = 0;
        @(posedge clk);
        #1;
        check("rst_mid_valid", 512'(out_valid), 512'(0));
        check("rst_mid_last", 512'(out_last), 512'(0));
        @(negedge clk);
        reset_n = 1;
        out_ready = 0;
        nreads = 3;
        for (int r = 0; r < nreads; r++) begin
            m_req[r] = $urandom_range(0, MM);
            m_ret[r] = $urandom_range(127);
        end
        collect(nreads);
        build_exp(nreads);
        run_stream(60, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
